// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready on both sides, a one-entry skid buffer,
// synchronous flush, decode-field slices of the held instruction and a stall counter.
module if_id_skid_reg #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_in,
  input  logic               flush_in,
  input  logic               if_valid_in,
  output logic               if_ready_out,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               id_valid_out,
  input  logic               id_ready_in,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [5:0]         opcode_out,
  output logic [4:0]         rs_out,
  output logic [4:0]         rt_out,
  output logic [4:0]         rd_out,
  output logic [15:0]        imm16_out,
  output logic [25:0]        jump26_out,
  output logic [CNT_W-1:0]   stall_cnt_out
);

  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic               mv;
  logic [PC_W-1:0]    s_pc;
  logic [INSTR_W-1:0] s_instr;
  logic               sv;
  logic [CNT_W-1:0]   stall_cnt;

  logic accept;
  logic m_free;
  logic stalled;

  // Ready comes straight from the skid valid flop, so decode backpressure
  // never reaches fetch combinationally.
  assign if_ready_out = ~sv;
  assign accept       = if_valid_in & ~sv;
  assign m_free       = ~mv | id_ready_in;
  assign stalled      = mv & ~id_ready_in;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      m_pc    <= '0;
      m_instr <= NOP_INSTR;
      mv      <= 1'b0;
      s_pc    <= '0;
      s_instr <= NOP_INSTR;
      sv      <= 1'b0;
    end else if (flush_in) begin
      m_pc    <= '0;
      m_instr <= NOP_INSTR;
      mv      <= 1'b0;
      sv      <= 1'b0;
    end else if (m_free) begin
      if (sv) begin
        m_pc    <= s_pc;
        m_instr <= s_instr;
        mv      <= 1'b1;
        sv      <= 1'b0;
      end else if (accept) begin
        m_pc    <= pc_in;
        m_instr <= instr_in;
        mv      <= 1'b1;
      end else begin
        mv      <= 1'b0;
      end
    end else if (accept) begin
      s_pc    <= pc_in;
      s_instr <= instr_in;
      sv      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      stall_cnt <= '0;
    end else if (!flush_in && stalled && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign id_valid_out  = mv;
  assign pc_out        = m_pc;
  assign instr_out     = m_instr;
  assign opcode_out    = m_instr[31:26];
  assign rs_out        = m_instr[25:21];
  assign rt_out        = m_instr[20:16];
  assign rd_out        = m_instr[15:11];
  assign imm16_out     = m_instr[15:0];
  assign jump26_out    = m_instr[25:0];
  assign stall_cnt_out = stall_cnt;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg; a second instance with a
// 3-bit counter shares the stimulus to exercise saturation.
module tb_if_id_skid_reg;

  logic        clk;
  logic        reset_in;
  logic        flush_in;
  logic        if_valid_in;
  logic        id_ready_in;
  logic [31:0] pc_in;
  logic [31:0] instr_in;

  logic        if_ready_out, id_valid_out;
  logic [31:0] pc_out, instr_out;
  logic [5:0]  opcode_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic [15:0] imm16_out;
  logic [25:0] jump26_out;
  logic [15:0] stall_cnt_out;

  logic        s_if_ready, s_id_valid;
  logic [31:0] s_pc_out, s_instr_out;
  logic [5:0]  s_opcode;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [15:0] s_imm16;
  logic [25:0] s_jump26;
  logic [2:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  if_id_skid_reg dut (
    .clk(clk), .reset_in(reset_in), .flush_in(flush_in),
    .if_valid_in(if_valid_in), .if_ready_out(if_ready_out),
    .pc_in(pc_in), .instr_in(instr_in),
    .id_valid_out(id_valid_out), .id_ready_in(id_ready_in),
    .pc_out(pc_out), .instr_out(instr_out), .opcode_out(opcode_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
    .imm16_out(imm16_out), .jump26_out(jump26_out),
    .stall_cnt_out(stall_cnt_out)
  );

  if_id_skid_reg #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset_in(reset_in), .flush_in(flush_in),
    .if_valid_in(if_valid_in), .if_ready_out(s_if_ready),
    .pc_in(pc_in), .instr_in(instr_in),
    .id_valid_out(s_id_valid), .id_ready_in(id_ready_in),
    .pc_out(s_pc_out), .instr_out(s_instr_out), .opcode_out(s_opcode),
    .rs_out(s_rs), .rt_out(s_rt), .rd_out(s_rd),
    .imm16_out(s_imm16), .jump26_out(s_jump26),
    .stall_cnt_out(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_in    = 1'b0;
    flush_in    = 1'b0;
    if_valid_in = 1'b0;
    id_ready_in = 1'b0;
    pc_in       = '0;
    instr_in    = '0;
    #1;
    check("rst_valid", id_valid_out, 0);
    check("rst_ready", if_ready_out, 1);
    check("rst_pc", pc_out, 0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_cnt", stall_cnt_out, 0);
    #11 reset_in = 1'b1;

    // Stream three lw instructions with decode always ready.
    id_ready_in = 1'b1;
    if_valid_in = 1'b1;
    instr_in    = 32'h8C41_0004;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'(i * 4);
      step();
      check("str_valid", id_valid_out, 1);
      check("str_pc", pc_out, 64'(i * 4));
      check("str_opc", opcode_out, 6'h23);
      check("str_rs", rs_out, 2);
      check("str_rt", rt_out, 1);
      check("str_imm", imm16_out, 16'h0004);
      check("str_ready", if_ready_out, 1);
    end
    if_valid_in = 1'b0;
    step();
    check("str_drain", id_valid_out, 0);

    // Stall absorb: 0x10 held in M, 0x14 into skid, 0x18 waits at fetch.
    if_valid_in = 1'b1; pc_in = 32'h10; instr_in = 32'h10;
    step();
    check("stl_pc10", pc_out, 32'h10);
    id_ready_in = 1'b0; pc_in = 32'h14; instr_in = 32'h14;
    step();
    check("stl_hold", pc_out, 32'h10);
    check("stl_rdy0", if_ready_out, 0);
    check("stl_cnt1", stall_cnt_out, 1);
    pc_in = 32'h18; instr_in = 32'h18;
    step();
    check("stl_hold2", pc_out, 32'h10);
    check("stl_rdy0b", if_ready_out, 0);
    step();
    check("stl_cnt3", stall_cnt_out, 3);
    id_ready_in = 1'b1;
    step();
    check("rel_pc14", pc_out, 32'h14);
    check("rel_valid", id_valid_out, 1);
    check("rel_rdy1", if_ready_out, 1);
    step();
    check("rel_pc18", pc_out, 32'h18);
    check("rel_instr", instr_out, 32'h18);
    if_valid_in = 1'b0;
    step();
    check("rel_drain", id_valid_out, 0);
    check("rel_cnt", stall_cnt_out, 3);

    // Flush with both M and S full while a new instruction is offered.
    id_ready_in = 1'b0; if_valid_in = 1'b1; pc_in = 32'h20; instr_in = 32'h20;
    step();
    pc_in = 32'h24; instr_in = 32'h24;
    step();
    check("fl_full", if_ready_out, 0);
    check("fl_cnt4", stall_cnt_out, 4);
    flush_in = 1'b1; pc_in = 32'h28; instr_in = 32'hDEAD_BEEF;
    step();
    check("fl_valid", id_valid_out, 0);
    check("fl_instr", instr_out, 32'h0);
    check("fl_pc", pc_out, 0);
    check("fl_ready", if_ready_out, 1);
    check("fl_cnt", stall_cnt_out, 4);
    flush_in = 1'b0; if_valid_in = 1'b0; id_ready_in = 1'b1;
    step();
    check("fl_gone", id_valid_out, 0);
    check("fl_gone_i", instr_out, 32'h0);

    // Flush and consume in the same cycle.
    if_valid_in = 1'b1; pc_in = 32'h30; instr_in = 32'h30;
    step();
    check("fc_valid", id_valid_out, 1);
    if_valid_in = 1'b0; flush_in = 1'b1;
    step();
    check("fc_empty", id_valid_out, 0);
    flush_in = 1'b0;

    // Jump field extraction.
    if_valid_in = 1'b1; pc_in = 32'h40; instr_in = 32'h0800_0040;
    step();
    check("j_opc", opcode_out, 6'h02);
    check("j_tgt", jump26_out, 26'h000_0040);
    if_valid_in = 1'b0;
    step();

    // Stall for ten cycles: 3-bit counter saturates at 7, 16-bit reaches 14.
    id_ready_in = 1'b0; if_valid_in = 1'b1; pc_in = 32'h50; instr_in = 32'h50;
    step();
    if_valid_in = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("sat_cnt3", s_stall_cnt, 7);
    check("sat_cnt16", stall_cnt_out, 14);

    // Asynchronous reset between clock edges while stalled.
    #3 reset_in = 1'b0;
    #1;
    check("ar_valid", id_valid_out, 0);
    check("ar_cnt", stall_cnt_out, 0);
    check("ar_cnt3", s_stall_cnt, 0);
    check("ar_ready", if_ready_out, 1);
    check("ar_instr", instr_out, 32'h0);
    #3 reset_in = 1'b1;
    step();
    check("ar_post", id_valid_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
